dc_pid_seq: RTL and testbench
=============================

Name: dc_pid_seq

Overview:
- Control sequencer for the 14-bit PID duty-cycle datapath.
- Drives the datapath's A/B selectors, register enables, subtract/saturate controls and Booth multiply controls to run one full PID update: err, sumerr, diferr, preverr, three Booth products, pid accumulate, duty update.
- Also loads setpoint from cfg_data and issues coefficient addresses to the EEPROM read port.
- Sits between the top-level loop timer/config interface and the datapath.

Parameters:
MULT_ITERS, 14, Booth iterations per multiply; must equal datapath operand width
EEP_AW, 2, width of coefficient address
COEF_P, 2'b00, EEPROM address of P gain
COEF_I, 2'b01, EEPROM address of I gain
COEF_D, 2'b10, EEPROM address of D gain

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
go  in  1  level request to run one PID update; sampled only in IDLE
cfg_wr  in  1  load xset from cfg_data; sampled only in IDLE
c_prod  in  2  Booth bits prod[1:0] from datapath
eep_addr  out  EEP_AW  coefficient address; eep_rd_data is valid combinationally while held
c_asel  out  3  A selector code
c_bsel  out  3  B selector code
c_err, c_duty, c_sumerr, c_diferr, c_xset, c_preverr, c_pid  out  1 each  datapath register enables
c_init_prod  out  1  load multiplier into product register
c_subtract  out  1  invert B and add 1
c_multsat  out  1  saturate from product MSBs
c_clr_duty  out  1  clear duty register
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse when duty is written and the sequence completes

Behaviour:
- Default outputs in IDLE/DONE: asel=ZEROA(111), bsel=ZEROB(011), all enables, subtract, multsat, init_prod = 0; eep_addr=COEF_P.
- Reset (async): state=IDLE, counter=0, busy=0, done=0, init flag set. c_clr_duty=1 for exactly the first clock after rst_n rises, then 0.
- IDLE priority: cfg_wr > go.
  - cfg_wr -> XSET, 1 cycle: asel CFGDATA, bsel ZEROB, c_xset=1.
  - go -> ERR.
- Scalar states, one cycle each:
  - ERR: XMEAS - XSET, sub=1, c_err.
  - SUM: ERR + SUMERRB, c_sumerr.
  - DIF: ERR - PREVERR, sub=1, c_diferr.
  - PREV: ERR + ZEROB, c_preverr.
- Term order: D, I, P. For each term, eep_addr is held from MINIT through MITER.
  - MINIT (1 cycle): asel = source (DIFERR / SUMERRA / ERR), bsel ZEROB, c_init_prod=1. Counter cleared.
  - MITER (MULT_ITERS cycles): asel PROD2815. Booth decode on c_prod:
    - 01: bsel EEPDATA, sub=0.
    - 10: bsel EEPDATA, sub=1.
    - 00/11: bsel ZEROB, sub=0.
  - MSTORE (1 cycle): asel ZEROA, bsel PROD2512, multsat=1.
    - D term: c_pid.
    - I and P terms: c_diferr; diferr is reused as scratch and is dead after the D multiply.
  - MACC (I, P only, 1 cycle): DIFERR + PID, multsat=0, c_pid.
- DUTY (1 cycle): DUTY + PID, c_duty.
- DONE (1 cycle): done=1, then IDLE.
- Latency: go sampled at edge 0 -> ERR cycle 1 … DUTY cycle 55, done high in cycle 56. Exactly 56 cycles, data-independent.
- go held through DONE starts the next update immediately after DONE returns to IDLE.
- cfg_wr/go while busy are ignored; they are not queued.
- Counter: 4-bit, wraps only by explicit clear in MINIT; MITER exits when counter == MULT_ITERS-1.
- Reset mid-operation: immediate IDLE; partial register writes stand; duty is cleared via the init flag.

Optional Feature:
- DC_PID_SEQ_ABORT_EN: adds input abort (1 bit).
- With macro: abort high in any non-IDLE state forces IDLE next cycle; that cycle drives default outputs; no c_duty write and no done pulse; sumerr/preverr keep any values already written.
- Without macro: port absent; the sequence always runs to DONE.

Decomposition:
- Package dc_pid_pkg: state enum; asel codes (CFGDATA..ZEROA); bsel codes (XSET..EEPDATA); COEF_* addresses; MULT_ITERS.
- Sub-module dc_booth_seq: MINIT/MITER/MSTORE sub-FSM, iteration counter and c_prod decode. Handshake with the parent is start/src_sel in, mult_done out.

Test Plan:
- Reset: rst_n low during MITER -> busy=0, asel=111, bsel=011, enables 0 asynchronously; first cycle after release c_clr_duty=1, then 0.
- cfg_wr with cfg_data=0x0100 -> one cycle of asel=000, bsel=011, c_xset=1; busy for 1 cycle; no done.
- Full loop on datapath model: xset=0x0100, xmeas=0x0080, P=0x1000, I=0, D=0, duty=0 -> pid=0x3F80, duty=0x3F80; done exactly 56 cycles after go.
- Booth decode in MITER: force c_prod=01/10/00/11 -> bsel=111 sub=0 / bsel=111 sub=1 / bsel=011 sub=0 / bsel=011 sub=0; eep_addr=10 during D term.
- go and cfg_wr together in IDLE with go held -> XSET cycle first, then ERR next cycle; cfg_wr pulse at cycle 20 ignored.
- (DC_PID_SEQ_ABORT_EN) abort at cycle 25 (I term) -> IDLE at cycle 26; c_duty never asserted; done stays 0.

Source files
------------

// File: rtl/dc_pid_pkg.sv
// Shared constants for the PID duty-cycle sequencer: state codes, selector codes,
// coefficient addresses and the ALU control bundle. No logic, no latency, no flow control.
package dc_pid_pkg;
    localparam int MULT_ITERS = 14;
    localparam int EEP_AW     = 2;

    localparam logic [EEP_AW-1:0] COEF_P = 2'b00;
    localparam logic [EEP_AW-1:0] COEF_I = 2'b01;
    localparam logic [EEP_AW-1:0] COEF_D = 2'b10;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_XSET   = 4'd1;
    localparam logic [3:0] ST_ERR    = 4'd2;
    localparam logic [3:0] ST_SUM    = 4'd3;
    localparam logic [3:0] ST_DIF    = 4'd4;
    localparam logic [3:0] ST_PREV   = 4'd5;
    localparam logic [3:0] ST_MULT_D = 4'd6;
    localparam logic [3:0] ST_MULT_I = 4'd7;
    localparam logic [3:0] ST_MACC_I = 4'd8;
    localparam logic [3:0] ST_MULT_P = 4'd9;
    localparam logic [3:0] ST_MACC_P = 4'd10;
    localparam logic [3:0] ST_DUTY   = 4'd11;
    localparam logic [3:0] ST_DONE   = 4'd12;

    localparam logic [1:0] B_INIT  = 2'd0;
    localparam logic [1:0] B_ITER  = 2'd1;
    localparam logic [1:0] B_STORE = 2'd2;

    localparam logic [2:0] ASEL_CFGDATA  = 3'd0;
    localparam logic [2:0] ASEL_XMEAS    = 3'd1;
    localparam logic [2:0] ASEL_ERR      = 3'd2;
    localparam logic [2:0] ASEL_SUMERRA  = 3'd3;
    localparam logic [2:0] ASEL_DIFERR   = 3'd4;
    localparam logic [2:0] ASEL_PROD2815 = 3'd5;
    localparam logic [2:0] ASEL_DUTY     = 3'd6;
    localparam logic [2:0] ASEL_ZEROA    = 3'd7;

    localparam logic [2:0] BSEL_XSET     = 3'd0;
    localparam logic [2:0] BSEL_SUMERRB  = 3'd1;
    localparam logic [2:0] BSEL_PREVERR  = 3'd2;
    localparam logic [2:0] BSEL_ZEROB    = 3'd3;
    localparam logic [2:0] BSEL_PID      = 3'd4;
    localparam logic [2:0] BSEL_PROD2512 = 3'd5;
    localparam logic [2:0] BSEL_RSVD     = 3'd6;
    localparam logic [2:0] BSEL_EEPDATA  = 3'd7;

    typedef struct packed {
        logic [2:0] asel;
        logic [2:0] bsel;
        logic       subtract;
        logic       multsat;
        logic       init_prod;
    } alu_ctl_t;
endpackage

// File: rtl/dc_booth_seq.sv
// Booth multiply sub-sequencer: MINIT, MULT_ITERS x MITER, MSTORE while start is held.
// Latency MULT_ITERS+2 cycles to mult_done; dropping start returns it to MINIT next cycle.
module dc_booth_seq
    import dc_pid_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] src_sel,
    input  logic [1:0] c_prod,
    output alu_ctl_t   ctl,
    output logic       mult_done
);
    logic [1:0] bstate;
    logic [1:0] bstate_nxt;
    logic [3:0] cnt;
    logic       last_iter;

    assign last_iter = (cnt == 4'(MULT_ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate <= B_INIT;
            cnt    <= '0;
        end else begin
            bstate <= start ? bstate_nxt : B_INIT;
            if (start && bstate == B_INIT)
                cnt <= '0;
            else if (start && bstate == B_ITER)
                cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        ctl        = '{asel: ASEL_ZEROA, bsel: BSEL_ZEROB, subtract: 1'b0, multsat: 1'b0, init_prod: 1'b0};
        mult_done  = 1'b0;
        bstate_nxt = bstate;
        if (start) begin
            case (bstate)
                B_INIT: begin
                    ctl.asel      = src_sel;
                    ctl.init_prod = 1'b1;
                    bstate_nxt    = B_ITER;
                end
                B_ITER: begin
                    ctl.asel = ASEL_PROD2815;
                    // radix-2 Booth: 01 adds the gain, 10 subtracts it, 00/11 only shift
                    case (c_prod)
                        2'b01:   ctl.bsel = BSEL_EEPDATA;
                        2'b10: begin
                            ctl.bsel     = BSEL_EEPDATA;
                            ctl.subtract = 1'b1;
                        end
                        default: ctl.bsel = BSEL_ZEROB;
                    endcase
                    if (last_iter)
                        bstate_nxt = B_STORE;
                end
                B_STORE: begin
                    ctl.bsel    = BSEL_PROD2512;
                    ctl.multsat = 1'b1;
                    mult_done   = 1'b1;
                    bstate_nxt  = B_INIT;
                end
                default: bstate_nxt = B_INIT;
            endcase
        end
    end
endmodule

// File: rtl/dc_pid_seq.sv
// PID duty-cycle control sequencer; fixed 56-cycle update from go to done, xset load in 1 cycle.
// No backpressure: go/cfg_wr only sampled when idle. Define DC_PID_SEQ_ABORT_EN to add the abort input.
module dc_pid_seq
    import dc_pid_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              cfg_wr,
`ifdef DC_PID_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic [1:0]        c_prod,
    output logic [EEP_AW-1:0] eep_addr,
    output logic [2:0]        c_asel,
    output logic [2:0]        c_bsel,
    output logic              c_err,
    output logic              c_duty,
    output logic              c_sumerr,
    output logic              c_diferr,
    output logic              c_xset,
    output logic              c_preverr,
    output logic              c_pid,
    output logic              c_init_prod,
    output logic              c_subtract,
    output logic              c_multsat,
    output logic              c_clr_duty,
    output logic              busy,
    output logic              done
);
    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       init_flag;
    logic       kill;
    logic       booth_start;
    logic [2:0] src_sel;
    alu_ctl_t   bctl;
    logic       mult_done;

`ifdef DC_PID_SEQ_ABORT_EN
    assign kill = abort && (state != ST_IDLE);
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            init_flag <= 1'b1;
        end else begin
            state     <= state_nxt;
            init_flag <= 1'b0;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign c_clr_duty = init_flag;

    assign booth_start = !kill && (state == ST_MULT_D || state == ST_MULT_I || state == ST_MULT_P);
    assign src_sel     = (state == ST_MULT_D) ? ASEL_DIFERR :
                         (state == ST_MULT_I) ? ASEL_SUMERRA : ASEL_ERR;

    dc_booth_seq u_booth (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (booth_start),
        .src_sel   (src_sel),
        .c_prod    (c_prod),
        .ctl       (bctl),
        .mult_done (mult_done)
    );

    always_comb begin
        state_nxt   = state;
        c_asel      = ASEL_ZEROA;
        c_bsel      = BSEL_ZEROB;
        c_err       = 1'b0;
        c_duty      = 1'b0;
        c_sumerr    = 1'b0;
        c_diferr    = 1'b0;
        c_xset      = 1'b0;
        c_preverr   = 1'b0;
        c_pid       = 1'b0;
        c_init_prod = 1'b0;
        c_subtract  = 1'b0;
        c_multsat   = 1'b0;
        eep_addr    = COEF_P;
        done        = 1'b0;
        if (kill) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_wr)  state_nxt = ST_XSET;
                    else if (go) state_nxt = ST_ERR;
                end
                ST_XSET: begin
                    c_asel = ASEL_CFGDATA;
                    c_xset = 1'b1;
                    // a go held alongside cfg_wr starts the update straight after the load
                    state_nxt = go ? ST_ERR : ST_IDLE;
                end
                ST_ERR: begin
                    c_asel = ASEL_XMEAS; c_bsel = BSEL_XSET; c_subtract = 1'b1; c_err = 1'b1;
                    state_nxt = ST_SUM;
                end
                ST_SUM: begin
                    c_asel = ASEL_ERR; c_bsel = BSEL_SUMERRB; c_sumerr = 1'b1;
                    state_nxt = ST_DIF;
                end
                ST_DIF: begin
                    c_asel = ASEL_ERR; c_bsel = BSEL_PREVERR; c_subtract = 1'b1; c_diferr = 1'b1;
                    state_nxt = ST_PREV;
                end
                ST_PREV: begin
                    c_asel = ASEL_ERR; c_preverr = 1'b1;
                    state_nxt = ST_MULT_D;
                end
                ST_MULT_D, ST_MULT_I, ST_MULT_P: begin
                    c_asel      = bctl.asel;
                    c_bsel      = bctl.bsel;
                    c_subtract  = bctl.subtract;
                    c_multsat   = bctl.multsat;
                    c_init_prod = bctl.init_prod;
                    if (state == ST_MULT_D) begin
                        eep_addr = COEF_D;
                        c_pid    = mult_done;
                        if (mult_done) state_nxt = ST_MULT_I;
                    end else if (state == ST_MULT_I) begin
                        eep_addr = COEF_I;
                        c_diferr = mult_done;   // diferr is dead after the D product
                        if (mult_done) state_nxt = ST_MACC_I;
                    end else begin
                        c_diferr = mult_done;
                        if (mult_done) state_nxt = ST_MACC_P;
                    end
                end
                ST_MACC_I, ST_MACC_P: begin
                    c_asel = ASEL_DIFERR; c_bsel = BSEL_PID; c_pid = 1'b1;
                    state_nxt = (state == ST_MACC_I) ? ST_MULT_P : ST_DUTY;
                end
                ST_DUTY: begin
                    c_asel = ASEL_DUTY; c_bsel = BSEL_PID; c_duty = 1'b1;
                    state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dc_pid_seq.sv
// Bench for dc_pid_seq with a behavioural 14-bit datapath; vector table plus scoreboard queue.
`timescale 1ns/1ps
module tb_dc_pid_seq;
    localparam logic [2:0] A_CFG = 3'd0, A_XMEAS = 3'd1, A_SUMA = 3'd3, A_PROD = 3'd5, A_ZERO = 3'd7;
    localparam logic [2:0] B_XSET = 3'd0, B_ZERO = 3'd3, B_P2512 = 3'd5, B_EEP = 3'd7;

    logic clk, rst_n, go, cfg_wr;
    logic [1:0] c_prod, eep_addr;
    logic [2:0] c_asel, c_bsel;
    logic c_err, c_duty, c_sumerr, c_diferr, c_xset, c_preverr, c_pid;
    logic c_init_prod, c_subtract, c_multsat, c_clr_duty, busy, done;
`ifdef DC_PID_SEQ_ABORT_EN
    logic abort;
`endif

    dc_pid_seq dut (
        .clk(clk), .rst_n(rst_n), .go(go), .cfg_wr(cfg_wr),
`ifdef DC_PID_SEQ_ABORT_EN
        .abort(abort),
`endif
        .c_prod(c_prod), .eep_addr(eep_addr), .c_asel(c_asel), .c_bsel(c_bsel),
        .c_err(c_err), .c_duty(c_duty), .c_sumerr(c_sumerr), .c_diferr(c_diferr),
        .c_xset(c_xset), .c_preverr(c_preverr), .c_pid(c_pid), .c_init_prod(c_init_prod),
        .c_subtract(c_subtract), .c_multsat(c_multsat), .c_clr_duty(c_clr_duty),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [13:0] cfg_data, xmeas, xset_r, err_r, sumerr_r, diferr_r, preverr_r, pid_r, duty_r;
    logic [28:0] prod_r;
    logic [27:0] product;
    logic [13:0] eep_mem [4];
    logic [13:0] a_val, b_val, alu;
    logic        force_en;
    logic [1:0]  force_prod;
    logic        en_any;

    assign product = prod_r[28:1];
    assign c_prod  = force_en ? force_prod : prod_r[1:0];
    assign en_any  = c_err | c_duty | c_sumerr | c_diferr | c_xset | c_preverr | c_pid;

    always_comb begin
        case (c_asel)
            3'd0: a_val = cfg_data;
            3'd1: a_val = xmeas;
            3'd2: a_val = err_r;
            3'd3: a_val = sumerr_r;
            3'd4: a_val = diferr_r;
            3'd5: a_val = prod_r[28:15];
            3'd6: a_val = duty_r;
            default: a_val = 14'd0;
        endcase
        case (c_bsel)
            3'd0: b_val = xset_r;
            3'd1: b_val = sumerr_r;
            3'd2: b_val = preverr_r;
            3'd4: b_val = pid_r;
            3'd5: b_val = product[25:12];   // Q12 gain scaling
            3'd7: b_val = eep_mem[eep_addr];
            default: b_val = 14'd0;
        endcase
        alu = a_val + (c_subtract ? ~b_val : b_val) + {13'd0, c_subtract};
        if (c_multsat && (product[27:25] != {3{product[25]}}))
            alu = product[27] ? 14'h2000 : 14'h1FFF;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= '0; xset_r <= '0; err_r <= '0; sumerr_r <= '0; diferr_r <= '0;
            preverr_r <= '0; pid_r <= '0; duty_r <= '0;
        end else begin
            if (c_init_prod)                prod_r <= {14'd0, alu, 1'b0};
            else if (busy && c_asel == A_PROD) prod_r <= {alu[13], alu, prod_r[14:1]};
            if (c_xset)    xset_r    <= alu;
            if (c_err)     err_r     <= alu;
            if (c_sumerr)  sumerr_r  <= alu;
            if (c_diferr)  diferr_r  <= alu;
            if (c_preverr) preverr_r <= alu;
            if (c_pid)     pid_r     <= alu;
            if (c_clr_duty)  duty_r <= '0;
            else if (c_duty) duty_r <= alu;
        end
    end

    // ---------------- scoreboard ----------------
    string       name_q[$];
    logic [31:0] val_q[$];
    int n_vec, n_bad;

    task automatic push(input string name, input logic [31:0] val);
        name_q.push_back(name);
        val_q.push_back(val);
    endtask

    task automatic pop(input logic [31:0] act);
        string nm;
        logic [31:0] ev;
        n_vec++;
        if (val_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty actual=%0h", act);
        end else begin
            nm = name_q.pop_front();
            ev = val_q.pop_front();
            if (act !== ev) begin
                n_bad++;
                $display("FAIL %s actual=%0h required=%0h", nm, act, ev);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ev);
        push(name, ev);
        pop(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input int start_n, output int n);
        n = start_n;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    typedef struct packed {
        logic [1:0] cp;
        logic [2:0] bsel;
        logic       sub;
    } bvec_t;
    bvec_t bv [4];

    initial begin
        int n;
        logic seen;
        bv[0] = {2'b01, B_EEP,  1'b0};
        bv[1] = {2'b10, B_EEP,  1'b1};
        bv[2] = {2'b00, B_ZERO, 1'b0};
        bv[3] = {2'b11, B_ZERO, 1'b0};
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; go = 1'b0; cfg_wr = 1'b0; force_en = 1'b0; force_prod = 2'b00;
        cfg_data = 14'h0000; xmeas = 14'h0000;
`ifdef DC_PID_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        eep_mem[0] = 14'h1000; eep_mem[1] = 14'h0000; eep_mem[2] = 14'h0000; eep_mem[3] = 14'h0000;

        // reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_asel", c_asel, A_ZERO);
        chk("rst_bsel", c_bsel, B_ZERO);
        chk("rst_done", done, 0);
        chk("rst_en", en_any, 0);
        rst_n = 1'b1;
        chk("clr_duty_first", c_clr_duty, 1);
        tick();
        chk("clr_duty_after", c_clr_duty, 0);

        // xset load
        cfg_data = 14'h0100; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        chk("xset_asel", c_asel, A_CFG);
        chk("xset_bsel", c_bsel, B_ZERO);
        chk("xset_en", c_xset, 1);
        chk("xset_busy", busy, 1);
        tick();
        chk("xset_idle", busy, 0);
        chk("xset_nodone", done, 0);

        // full update with P gain only
        xmeas = 14'h0080; go = 1'b1;
        push("loop_latency", 56); push("loop_pid", 14'h3F80); push("loop_duty", 14'h3F80);
        tick();
        go = 1'b0;
        run_to_done(1, n);
        pop(32'(n)); pop({18'd0, pid_r}); pop({18'd0, duty_r});
        tick();
        chk("done_pulse", done, 0);
        chk("done_idle", busy, 0);

        // Booth decode table in the D term, then a cfg_wr ignored while busy
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            force_en = 1'b1; force_prod = bv[i].cp;
            push("booth_bsel", bv[i].bsel); push("booth_sub", bv[i].sub);
            push("booth_eep", 2'b10); push("booth_asel", A_PROD);
            #1;
            pop(c_bsel); pop(c_subtract); pop(eep_addr); pop(c_asel);
            tick();
        end
        force_en = 1'b0;
        repeat (10) tick();
        cfg_wr = 1'b1;
        chk("mstore_d_pid", c_pid, 1);
        chk("mstore_d_bsel", c_bsel, B_P2512);
        tick();
        cfg_wr = 1'b0;
        chk("busy_cfg_ignored", c_xset, 0);
        chk("minit_i_asel", c_asel, A_SUMA);
        chk("minit_i_eep", eep_addr, 2'b01);
        run_to_done(21, n);
        chk("booth_run_latency", n, 56);

        // cfg_wr and go together, go held through DONE
        tick();
        cfg_data = 14'h0100; cfg_wr = 1'b1; go = 1'b1;
        tick();
        cfg_wr = 1'b0;
        chk("both_xset_first", c_xset, 1);
        chk("both_no_err", c_err, 0);
        tick();
        chk("both_err_en", c_err, 1);
        chk("both_err_asel", c_asel, A_XMEAS);
        chk("both_err_bsel", c_bsel, B_XSET);
        chk("both_err_sub", c_subtract, 1);
        run_to_done(1, n);
        chk("held_latency", n, 56);
        tick();
        chk("held_idle", busy, 0);
        tick();
        chk("held_restart", c_err, 1);
        go = 1'b0;
        run_to_done(1, n);
        chk("restart_latency", n, 56);
        tick();

`ifdef DC_PID_SEQ_ABORT_EN
        // abort in the I term
        go = 1'b1;
        tick();
        go = 1'b0;
        seen = 1'b0;
        repeat (24) begin
            seen = seen | c_duty | done;
            tick();
        end
        abort = 1'b1;
        #1;
        chk("abort_defaults", c_asel, A_ZERO);
        tick();
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        repeat (40) begin
            seen = seen | c_duty | done;
            tick();
        end
        chk("abort_no_duty_done", seen, 0);
`endif

        // reset in the middle of MITER
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (9) tick();
        chk("mid_in_miter", c_asel, A_PROD);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_asel", c_asel, A_ZERO);
        chk("mid_rst_bsel", c_bsel, B_ZERO);
        chk("mid_rst_en", en_any, 0);
        tick();
        rst_n = 1'b1;
        chk("mid_clr_first", c_clr_duty, 1);
        tick();
        chk("mid_clr_after", c_clr_duty, 0);
        chk("mid_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
